// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: pcsrc encoding, the bubble instruction word
// and the fetch FSM states.
package cpu_pkg;

  localparam logic [1:0]  PCSRC_SEQ = 2'b00;
  localparam logic [1:0]  PCSRC_BR  = 2'b01;
  localparam logic [31:0] NOP_INST  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    HOLD = 2'b10
  } fetch_state_t;

  // Any pcsrc with bit 1 set is a jump; 01 is a branch. Result is word aligned.
  function automatic logic [31:0] redirect_target(input logic [1:0]  pcsrc,
                                                  input logic [31:0] bpc,
                                                  input logic [31:0] jpc);
    logic [31:0] tgt;
    if (pcsrc[1]) begin
      tgt = jpc;
    end else begin
      tgt = bpc;
    end
    return {tgt[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register for {valid, inst, pc4} with load, bubble and hold.
module if_id_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] d_inst,
  input  logic [31:0] d_pc4,
  output logic        valid,
  output logic [31:0] inst,
  output logic [31:0] pc4
);

  // Load wins over bubble; a bubble keeps pc4 so decode sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc4   <= 32'h0000_0000;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= d_inst;
      pc4   <= d_pc4;
    end else if (bubble) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc4   <= pc4;
    end else begin
      valid <= valid;
      inst  <= inst;
      pc4   <= pc4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage with IF/ID register: variable-latency instruction fetch,
// stall hold buffer and delayed-branch redirect.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4
);

  fetch_state_t state_r, state_next_s;
  logic [31:0]  pc_r, hold_inst_r, hold_pc4_r, pend_tgt_r;
  logic         pend_v_r;

  logic         complete_s, consume_s;
  logic [31:0]  pc4_s, target_s;
  logic         load_s, bubble_s;
  logic [31:0]  d_inst_s, d_pc4_s;

  assign pc4_s      = pc_r + 32'd4;
  assign complete_s = (state_r == REQ) && imem_ready;
  assign consume_s  = !stall && if_id_valid && (pcsrc != PCSRC_SEQ);
  assign target_s   = redirect_target(pcsrc, bpc, jpc);
  assign imem_addr  = pc_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = REQ;
      REQ:     if (complete_s && stall) state_next_s = HOLD; else state_next_s = REQ;
      HOLD:    if (!stall) state_next_s = REQ; else state_next_s = HOLD;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: request line and IF/ID register control.
  always_comb begin
    imem_req = 1'b0;
    load_s   = 1'b0;
    bubble_s = 1'b0;
    d_inst_s = imem_rdata;
    d_pc4_s  = pc4_s;
    case (state_r)
      REQ: begin
        imem_req = 1'b1;
        if (!stall) begin
          load_s   = complete_s;
          bubble_s = !complete_s;
        end else begin
          load_s   = 1'b0;
          bubble_s = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          load_s   = 1'b1;
          d_inst_s = hold_inst_r;
          d_pc4_s  = hold_pc4_r;
        end else begin
          load_s   = 1'b0;
        end
      end
      default: imem_req = 1'b0;
    endcase
  end

  // PC, hold buffer and pending redirect. The delay slot is always the word
  // fetched after the branch, so a redirect lands on the fetch following it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      pend_v_r    <= 1'b0;
      pend_tgt_r  <= 32'h0000_0000;
      hold_inst_r <= 32'h0000_0000;
      hold_pc4_r  <= 32'h0000_0000;
    end else begin
      if (complete_s) begin
        if (consume_s) begin
          pc_r <= target_s;
        end else if (pend_v_r) begin
          pc_r <= pend_tgt_r;
        end else begin
          pc_r <= pc4_s;
        end
        pend_v_r <= 1'b0;
      end else if ((state_r == HOLD) && consume_s) begin
        pc_r <= target_s;
      end else if ((state_r == REQ) && consume_s) begin
        pend_v_r   <= 1'b1;
        pend_tgt_r <= target_s;
      end else begin
        pc_r <= pc_r;
      end
      if (complete_s && stall) begin
        hold_inst_r <= imem_rdata;
        hold_pc4_r  <= pc4_s;
      end else begin
        hold_inst_r <= hold_inst_r;
        hold_pc4_r  <= hold_pc4_r;
      end
    end
  end

  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .bubble (bubble_s),
    .d_inst (d_inst_s),
    .d_pc4  (d_pc4_s),
    .valid  (if_id_valid),
    .inst   (if_id_inst),
    .pc4    (if_id_pc4)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns the address as data.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        if_id_valid;
  logic [31:0] if_id_inst, if_id_pc4;

  int n_vec = 0;
  int n_err = 0;

  assign imem_rdata = imem_addr;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .pcsrc       (pcsrc),
    .bpc         (bpc),
    .jpc         (jpc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .if_id_valid (if_id_valid),
    .if_id_inst  (if_id_inst),
    .if_id_pc4   (if_id_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the visible fetch/IF-ID state after the latest edge.
  task automatic expect_st(input string tag, input logic req, input logic [31:0] addr,
                           input logic v, input logic [31:0] inst, input logic [31:0] pc4);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, v});
    chk({tag, ".inst"},  if_id_inst, inst);
    chk({tag, ".pc4"},   if_id_pc4, pc4);
  endtask

  // Reset, then run until IF/ID holds the word at 0x8 and 0xC is requested.
  task automatic restart();
    rst = 1'b1; pcsrc = 2'b00; stall = 1'b0; imem_ready = 1'b1;
    step();
    rst = 1'b0;
    step(); step(); step(); step();
    expect_st("restart", 1'b1, 32'hC, 1'b1, 32'h8, 32'hC);
  endtask

  initial begin
    rst = 1'b1; pcsrc = 2'b00; bpc = 32'h0; jpc = 32'h0; stall = 1'b0; imem_ready = 1'b1;
    step();
    expect_st("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Back-to-back fetches.
    rst = 1'b0;
    step(); expect_st("seq0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(); expect_st("seq1", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4);
    step(); expect_st("seq2", 1'b1, 32'h8, 1'b1, 32'h4, 32'h8);

    // Two wait states on 0x8 give two bubbles.
    imem_ready = 1'b0;
    step(); expect_st("wait0", 1'b1, 32'h8, 1'b0, 32'h0, 32'h8);
    step(); expect_st("wait1", 1'b1, 32'h8, 1'b0, 32'h0, 32'h8);
    imem_ready = 1'b1;
    step(); expect_st("wait2", 1'b1, 32'hC, 1'b1, 32'h8, 32'hC);

    // Stall while 0xC completes; a redirect during stall is ignored.
    stall = 1'b1; pcsrc = 2'b01; bpc = 32'h40;
    step(); expect_st("stall0", 1'b0, 32'h0, 1'b1, 32'h8, 32'hC);
    step(); expect_st("stall1", 1'b0, 32'h0, 1'b1, 32'h8, 32'hC);
    step(); expect_st("stall2", 1'b0, 32'h0, 1'b1, 32'h8, 32'hC);
    stall = 1'b0; pcsrc = 2'b00;
    step(); expect_st("unstall", 1'b1, 32'h10, 1'b1, 32'hC, 32'h10);
    step(); expect_st("post", 1'b1, 32'h14, 1'b1, 32'h10, 32'h14);

    // Taken branch at 0x8 with immediate delay slot.
    restart();
    pcsrc = 2'b01; bpc = 32'h40; jpc = 32'h100;
    step(); expect_st("br.ds", 1'b1, 32'h40, 1'b1, 32'hC, 32'h10);
    pcsrc = 2'b00;
    step(); expect_st("br.tgt", 1'b1, 32'h44, 1'b1, 32'h40, 32'h44);

    // Jump uses jpc (low bits cleared), not bpc.
    restart();
    pcsrc = 2'b11; bpc = 32'h40; jpc = 32'h102;
    step(); expect_st("j.ds", 1'b1, 32'h100, 1'b1, 32'hC, 32'h10);
    pcsrc = 2'b00;
    step(); expect_st("j.tgt", 1'b1, 32'h104, 1'b1, 32'h100, 32'h104);

    // Jump to the top word: pc wraps to 0.
    restart();
    pcsrc = 2'b10; jpc = 32'hFFFF_FFFC;
    step(); expect_st("wrap.ds", 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hC, 32'h10);
    pcsrc = 2'b00;
    step(); expect_st("wrap", 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'h0);

    // Branch consumed while the delay slot is outstanding.
    restart();
    imem_ready = 1'b0; pcsrc = 2'b01; bpc = 32'h40;
    step(); expect_st("pend0", 1'b1, 32'hC, 1'b0, 32'h0, 32'hC);
    pcsrc = 2'b00;
    step(); expect_st("pend1", 1'b1, 32'hC, 1'b0, 32'h0, 32'hC);
    step(); expect_st("pend2", 1'b1, 32'hC, 1'b0, 32'h0, 32'hC);
    imem_ready = 1'b1;
    step(); expect_st("pend.ds", 1'b1, 32'h40, 1'b1, 32'hC, 32'h10);

    // Reset during the pending wait discards the redirect.
    restart();
    imem_ready = 1'b0; pcsrc = 2'b01; bpc = 32'h40;
    step(); expect_st("prst0", 1'b1, 32'hC, 1'b0, 32'h0, 32'hC);
    pcsrc = 2'b00; rst = 1'b1;
    step(); expect_st("prst.rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0; imem_ready = 1'b1;
    step(); expect_st("prst.idle", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step(); expect_st("prst.seq", 1'b1, 32'h4, 1'b1, 32'h0, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the decode-stage control unit.
- Holds the PC and fetches words from instruction memory over a variable-latency req/ready handshake.
- Presents op/func (inst) and pc+4 to decode, and applies the control unit's pcsrc redirect with one architectural delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- NOP_INST, 32'h0000_0000, instruction word driven on a bubble (sll $0,$0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- pcsrc  in  2  from control unit: 00 = pc+4, 01 = branch (bpc), 1x = jump (jpc); j arrives as 11.
- bpc  in  32  branch target from decode.
- jpc  in  32  jump target from decode.
- stall  in  1  hazard freeze: IF/ID holds, branch not consumed.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; word aligned.
- imem_rdata  in  32  fetched word; valid when imem_req & imem_ready.
- imem_ready  in  1  completes the current request this cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  instruction to decode (op = [31:26], func = [5:0]).
- if_id_pc4  out  32  address of that instruction + 4.

Behaviour:
- State: pc (next address to fetch), fsm {IDLE, REQ, HOLD}, hold_inst/hold_pc4 buffer, pend_v/pend_tgt redirect register.
- Reset (rst=1 at an edge):
  - pc = RESET_PC, fsm = IDLE, pend_v = 0.
  - if_id_valid = 0, if_id_inst = NOP_INST, if_id_pc4 = 0, imem_req = 0.
  - Reset mid-fetch abandons the request; imem_req is low the next cycle.
- IDLE: imem_req = 0; next state is REQ.
- REQ:
  - imem_req = 1, imem_addr = pc; addr stays stable until imem_ready.
  - A fetch completes in a cycle where imem_ready = 1.
  - Completion with stall = 0: IF/ID <= {1, rdata, pc+4}; pc <= next_pc; stay in REQ, so back-to-back fetches give 1 instruction/cycle.
  - Completion with stall = 1: word goes to hold buffer; pc <= next_pc; go to HOLD.
  - No completion with stall = 0: IF/ID <= bubble {0, NOP_INST, if_id_pc4 unchanged}.
  - No completion with stall = 1: IF/ID unchanged.
- HOLD:
  - imem_req = 0.
  - stall = 0: IF/ID <= hold buffer (valid = 1); go to REQ, so the next request issues in the following cycle.
  - stall = 1: remain in HOLD.
- Branch consume:
  - Happens in a cycle with stall = 0, if_id_valid = 1 and pcsrc != 00.
  - Target = pcsrc[1] ? jpc : bpc; bits [1:0] are forced to 00.
  - The delay slot is the word fetched after the branch. It is always delivered, never flushed.
  - Delay slot completing this same cycle, or already in the hold buffer: pc <= target, overriding next_pc.
  - Delay slot still outstanding (REQ, no ready): pend_tgt <= target, pend_v <= 1. On the completion of that fetch, pc <= pend_tgt and pend_v <= 0.
  - pcsrc is ignored when if_id_valid = 0 or stall = 1.
- next_pc = pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- Delay slot already in IF/ID while the branch is unconsumed is not possible; IF/ID advances only on a consume or a bubble.

Decomposition:
- Shared package (cpu_pkg):
  - PCSRC_SEQ = 2'b00, PCSRC_BR = 2'b01, PCSRC_J = 2'b1x decode rule.
  - NOP_INST.
  - fetch_state_t {IDLE, REQ, HOLD}.
- Sub-module if_id_reg: load/hold/bubble register for {valid, inst, pc4}, with synchronous reset. Reused for the other pipeline registers.
- PC, FSM, hold buffer and pend logic stay in fetch_stage.

Test Plan:
- Reset then imem_ready tied 1, memory returns addr as data → imem_addr 0,4,8 on consecutive cycles; if_id_pc4 4,8,12; if_id_inst 0,4,8; valid = 1 from the 2nd cycle after reset.
- imem_ready low 2 cycles on addr 0x8 → imem_addr holds 0x8 for 3 cycles; IF/ID shows 2 bubbles (valid = 0, inst = 0), then inst = 0x8.
- stall = 1 for 3 cycles while fetch 0xC completes → imem_req drops in HOLD; IF/ID frozen; 0xC enters IF/ID the cycle after stall drops; next request is 0x10.
- beq at 0x8 in IF/ID with pcsrc = 01, bpc = 0x40, ready = 1 → fetch sequence 0xC (delay slot, delivered valid), then 0x40.
- j at 0x8 with pcsrc = 11, jpc = 0x100, bpc = 0x40 → after delay slot 0xC the next fetch is 0x100, not 0x40.
- Taken branch consumed while the 0xC fetch waits 3 cycles → pend_v set, IF/ID bubbles; on ready, the next request is the target. Repeat with rst during the wait → imem_req = 0, pend_v = 0, restart at RESET_PC.
